// File: rtl/display_tile_mapper_if.sv
// Handshake and data bundle between a display position source and the tile mapper.
// The slave modport is the mapper's view; the master modport is the source/sink side.
interface display_tile_mapper_if #(
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int IDX_X_W    = 7,
  parameter int IDX_Y_W    = 6,
  parameter int TILE_SHIFT = 4
);
  logic [X_W-1:0]        display_pos_x;
  logic [Y_W-1:0]        display_pos_y;
  logic                  in_valid;
  logic                  in_ready;
  logic [IDX_X_W-1:0]    matrix_idx_x;
  logic [IDX_Y_W-1:0]    matrix_idx_y;
  logic [TILE_SHIFT-1:0] sub_x;
  logic [TILE_SHIFT-1:0] sub_y;
  logic                  in_map;
  logic                  tile_change;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output display_pos_x, display_pos_y, in_valid, out_ready,
    input  in_ready, matrix_idx_x, matrix_idx_y, sub_x, sub_y,
           in_map, tile_change, out_valid
  );

  modport slave (
    input  display_pos_x, display_pos_y, in_valid, out_ready,
    output in_ready, matrix_idx_x, matrix_idx_y, sub_x, sub_y,
           in_map, tile_change, out_valid
  );
endinterface

// File: rtl/display_tile_mapper.sv
// Maps a display position to a tile index of a MAP_W x MAP_H tile map.
// Stage 1 removes the visible-area origin and centring offset; stage 2 clamps
// to the map, splits into tile index / in-tile offset and flags tile changes
// relative to the last beat the consumer actually took.
module display_tile_mapper #(
  parameter int H_VISIBLE_START = 336,
  parameter int V_VISIBLE_START = 27,
  parameter int CENTER_OFFSET   = 7,
  parameter int TILE_SHIFT      = 4,
  parameter int MAP_W           = 80,
  parameter int MAP_H           = 50,
  parameter int X_W             = 11,
  parameter int Y_W             = 10,
  parameter int IDX_X_W         = 7,
  parameter int IDX_Y_W         = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  display_tile_mapper_if.slave bus
);

  // Relative positions carry two extra bits so negative results never wrap.
  localparam logic signed [X_W+1:0] X_OFF = (X_W+2)'(H_VISIBLE_START + CENTER_OFFSET);
  localparam logic signed [Y_W+1:0] Y_OFF = (Y_W+2)'(V_VISIBLE_START + CENTER_OFFSET);
  localparam logic signed [X_W+1:0] X_LIM = (X_W+2)'(MAP_W << TILE_SHIFT);
  localparam logic signed [Y_W+1:0] Y_LIM = (Y_W+2)'(MAP_H << TILE_SHIFT);
  localparam logic [IDX_X_W-1:0]    X_IDX_MAX = IDX_X_W'(MAP_W - 1);
  localparam logic [IDX_Y_W-1:0]    Y_IDX_MAX = IDX_Y_W'(MAP_H - 1);

  // Stage 1 state
  logic                    s1_valid;
  logic signed [X_W+1:0]   rel_x;
  logic signed [Y_W+1:0]   rel_y;

  // Stage 2 state (drives the outputs directly)
  logic                    s2_valid;
  logic [IDX_X_W-1:0]      idx_x_q;
  logic [IDX_Y_W-1:0]      idx_y_q;
  logic [TILE_SHIFT-1:0]   sub_x_q;
  logic [TILE_SHIFT-1:0]   sub_y_q;
  logic                    in_map_q;
  logic                    tile_change_q;

  // Reference tile of the last transferred beat
  logic [IDX_X_W-1:0]      ref_x;
  logic [IDX_Y_W-1:0]      ref_y;
  logic                    first_beat;

  // Stage 2 next values
  logic                    x_neg, x_over, y_neg, y_over;
  logic [IDX_X_W-1:0]      nx_idx_x;
  logic [IDX_Y_W-1:0]      nx_idx_y;
  logic [TILE_SHIFT-1:0]   nx_sub_x;
  logic [TILE_SHIFT-1:0]   nx_sub_y;
  logic                    nx_in_map;
  logic                    nx_tile_change;

  logic xfer;
  logic s2_load;

  assign xfer         = s2_valid && bus.out_ready;
  assign s2_load      = !s2_valid || bus.out_ready;
  // Stage 1 can only be blocked when both stages hold data and the sink stalls.
  assign bus.in_ready = !(s1_valid && s2_valid && !bus.out_ready);

  assign bus.out_valid    = s2_valid;
  assign bus.matrix_idx_x = idx_x_q;
  assign bus.matrix_idx_y = idx_y_q;
  assign bus.sub_x        = sub_x_q;
  assign bus.sub_y        = sub_y_q;
  assign bus.in_map       = in_map_q;
  assign bus.tile_change  = tile_change_q;

  // Stage 1: capture the offset-corrected position on acceptance.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      rel_x    <= '0;
      rel_y    <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        rel_x <= $signed({2'b00, bus.display_pos_x}) - X_OFF;
        rel_y <= $signed({2'b00, bus.display_pos_y}) - Y_OFF;
      end
    end
  end

  // Stage 2 combinational: clamp, split, and compare against the reference tile.
  always_comb begin
    // NOTE: every output of this block is given a default first so no latch can be inferred.
    x_neg          = rel_x[X_W+1];
    y_neg          = rel_y[Y_W+1];
    x_over         = !x_neg && (rel_x >= X_LIM);
    y_over         = !y_neg && (rel_y >= Y_LIM);
    nx_idx_x       = rel_x[TILE_SHIFT +: IDX_X_W];
    nx_idx_y       = rel_y[TILE_SHIFT +: IDX_Y_W];
    nx_in_map      = !x_neg && !x_over && !y_neg && !y_over;
    nx_sub_x       = '0;
    nx_sub_y       = '0;
    nx_tile_change = 1'b0;

    if (x_neg)       nx_idx_x = '0;
    else if (x_over) nx_idx_x = X_IDX_MAX;
    if (y_neg)       nx_idx_y = '0;
    else if (y_over) nx_idx_y = Y_IDX_MAX;

    if (nx_in_map) begin
      nx_sub_x = rel_x[TILE_SHIFT-1:0];
      nx_sub_y = rel_y[TILE_SHIFT-1:0];
    end

    // The beat leaving this cycle becomes the reference for the one entering.
    if (xfer) nx_tile_change = (nx_idx_x != idx_x_q) || (nx_idx_y != idx_y_q);
    else      nx_tile_change = first_beat || (nx_idx_x != ref_x) || (nx_idx_y != ref_y);
  end

  // Stage 2 registers plus the tile-change reference, updated only on transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid      <= 1'b0;
      idx_x_q       <= '0;
      idx_y_q       <= '0;
      sub_x_q       <= '0;
      sub_y_q       <= '0;
      in_map_q      <= 1'b0;
      tile_change_q <= 1'b0;
      ref_x         <= '0;
      ref_y         <= '0;
      first_beat    <= 1'b1;
    end else begin
      if (xfer) begin
        ref_x      <= idx_x_q;
        ref_y      <= idx_y_q;
        first_beat <= 1'b0;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          idx_x_q       <= nx_idx_x;
          idx_y_q       <= nx_idx_y;
          sub_x_q       <= nx_sub_x;
          sub_y_q       <= nx_sub_y;
          in_map_q      <= nx_in_map;
          tile_change_q <= nx_tile_change;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_tile_mapper.sv
// Bench for display_tile_mapper: directed vectors plus randomized traffic,
// scored against a transaction-level model of the position-to-tile mapping.
module tb_display_tile_mapper;

  localparam int H0   = 336;
  localparam int V0   = 27;
  localparam int COFF = 7;
  localparam int TS   = 4;
  localparam int TILE = 1 << TS;
  localparam int MW   = 80;
  localparam int MH   = 50;

  typedef struct {
    int x;
    int y;
  } pos_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  display_tile_mapper_if bus ();

  display_tile_mapper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  pos_t exp_q[$];
  logic model_first = 1'b1;
  int   last_ix = 0;
  int   last_iy = 0;
  int   tc_count = 0;

  logic       held = 1'b0;
  logic [6:0] held_ix;
  logic [5:0] held_iy;
  logic [3:0] held_sx;
  logic [3:0] held_sy;
  logic       held_map;
  logic       held_tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference mapping computed directly from the tile geometry.
  task automatic model(input int x, input int y, output int ix, output int iy,
                       output int sx, output int sy, output int inm);
    int rx, ry;
    rx  = x - H0 - COFF;
    ry  = y - V0 - COFF;
    inm = (rx >= 0 && rx < MW * TILE && ry >= 0 && ry < MH * TILE) ? 1 : 0;
    ix  = (rx < 0) ? 0 : (rx >= MW * TILE) ? MW - 1 : rx / TILE;
    iy  = (ry < 0) ? 0 : (ry >= MH * TILE) ? MH - 1 : ry / TILE;
    sx  = inm ? rx % TILE : 0;
    sy  = inm ? ry % TILE : 0;
  endtask

  // One clock: drive inputs, observe handshakes, advance to the next falling edge.
  task automatic step(input logic v, input int x, input int y, input logic ordy);
    int   ix, iy, sx, sy, inm, etc;
    pos_t p;
    bus.in_valid      = v;
    bus.display_pos_x = x[10:0];
    bus.display_pos_y = y[9:0];
    bus.out_ready     = ordy;
    #1;
    if (held) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_ix", bus.matrix_idx_x, held_ix);
      check("hold_iy", bus.matrix_idx_y, held_iy);
      check("hold_sx", bus.sub_x, held_sx);
      check("hold_sy", bus.sub_y, held_sy);
      check("hold_map", bus.in_map, held_map);
      check("hold_tc", bus.tile_change, held_tc);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", bus.out_valid, 0);
      end else begin
        p = exp_q.pop_front();
        model(p.x, p.y, ix, iy, sx, sy, inm);
        etc = (model_first || ix != last_ix || iy != last_iy) ? 1 : 0;
        check("idx_x", bus.matrix_idx_x, ix);
        check("idx_y", bus.matrix_idx_y, iy);
        check("sub_x", bus.sub_x, sx);
        check("sub_y", bus.sub_y, sy);
        check("in_map", bus.in_map, inm);
        check("tile_change", bus.tile_change, etc);
        if (bus.tile_change) tc_count++;
        model_first = 1'b0;
        last_ix = ix;
        last_iy = iy;
      end
    end
    held     = bus.out_valid && !bus.out_ready;
    held_ix  = bus.matrix_idx_x;
    held_iy  = bus.matrix_idx_y;
    held_sx  = bus.sub_x;
    held_sy  = bus.sub_y;
    held_map = bus.in_map;
    held_tc  = bus.tile_change;
    if (bus.in_valid && bus.in_ready) begin
      p.x = x & 32'h7FF;
      p.y = y & 32'h3FF;
      exp_q.push_back(p);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_first = 1'b1;
    held = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_idx_x", bus.matrix_idx_x, 0);
    check("rst_tc", bus.tile_change, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b0, int'($urandom), int'($urandom), 1'b1);
    check("drained", exp_q.size(), 0);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.display_pos_x = '0;
    bus.display_pos_y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // First beat latency and tile_change on first beat.
    step(1'b1, 343, 34, 1'b1);
    check("lat_cycle1", bus.out_valid, 0);
    step(1'b0, 0, 0, 1'b1);
    check("lat_cycle2", bus.out_valid, 1);
    check("lat_tc", bus.tile_change, 1);
    drain();

    // Map corner, just past it, just before origin, and far negative.
    step(1'b1, 1622, 833, 1'b1);
    step(1'b1, 1623, 833, 1'b1);
    step(1'b1, 342, 34, 1'b1);
    step(1'b1, 0, 0, 1'b1);
    drain();

    // Horizontal sweep across two tile boundaries.
    do_reset();
    tc_count = 0;
    for (int x = 343; x <= 375; x++) step(1'b1, x, 34, 1'b1);
    drain();
    check("sweep_tc_count", tc_count, 3);

    // Sink stall: pipeline holds exactly two beats and back-pressures.
    for (int i = 0; i < 4; i++) step(1'b1, 400 + 16 * i, 60, 1'b0);
    check("stall_inflight", exp_q.size(), 2);
    check("stall_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 500 + 16 * i, 100, 1'b1);
    drain();

    // Reset with two beats in flight discards them.
    step(1'b1, 700, 300, 1'b0);
    step(1'b1, 720, 300, 1'b0);
    do_reset();
    step(1'b0, 0, 0, 1'b1);
    check("post_rst_empty", bus.out_valid, 0);
    step(1'b1, 700, 300, 1'b1);
    drain();

    // Randomized traffic with random stalls and idle gaps.
    for (int i = 0; i < 600; i++) begin
      int rx, ry;
      if ($urandom_range(0, 9) == 0) begin
        rx = int'($urandom_range(0, 2047));
        ry = int'($urandom_range(0, 1023));
      end else begin
        rx = int'($urandom_range(320, 1650));
        ry = int'($urandom_range(10, 860));
      end
      step(($urandom_range(0, 3) != 0), rx, ry, ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
